// File: rtl/uart_bus_seq.sv
// Multi-cycle UART access sequencer between the MEM stage and the shared Ram1 bus.
// Optional build macro UART_TX_WAIT_EN: writes wait in WAIT_TX until tbre&&tsre before the strobe sequence.
module uart_bus_seq #(
    parameter logic [15:0] SERIAL_DATA   = 16'hBF00,
    parameter logic [15:0] SERIAL_STATUS = 16'hBF01,
    parameter int unsigned SETUP_CYC     = 1,
    parameter int unsigned PULSE_CYC     = 2,
    parameter int unsigned HOLD_CYC      = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [15:0] RData,
    output logic        Stall,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn,
    output logic        bus_oe,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_TX = 3'd1,
        S_SETUP   = 3'd2,
        S_STROBE  = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    function automatic logic [15:0] status_word(input logic rx_ready, input logic tx_empty);
        return {14'd0, rx_ready, tx_empty};
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic        r_is_write;
    logic        w_next_write;
    logic        r_rdn;
    logic        r_wrn;
    logic        r_bus_oe;
    logic [15:0] r_bus_dout;
    logic [15:0] r_rdata;
    logic        w_req;
    logic        w_req_write;
    logic        w_status_rd;
    logic        w_tx_ready;
    logic        w_busy;

    assign w_req       = (MemRead | MemWrite) && (Addr == SERIAL_DATA);
    assign w_req_write = MemWrite & ~MemRead;
    assign w_status_rd = MemRead && (Addr == SERIAL_STATUS);
    assign w_tx_ready  = tbre & tsre;

    // Next-state and dwell-counter logic; the counter reloads on every state entry.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
`ifdef UART_TX_WAIT_EN
                    if (w_req_write) begin
                        w_next_state = S_WAIT_TX;
                        w_next_cnt   = 4'd0;
                    end else begin
                        w_next_state = S_SETUP;
                        w_next_cnt   = SETUP_LD;
                    end
`else
                    w_next_state = S_SETUP;
                    w_next_cnt   = SETUP_LD;
`endif
                end else begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = 4'd0;
                end
            end
`ifdef UART_TX_WAIT_EN
            S_WAIT_TX: begin
                if (w_tx_ready) begin
                    w_next_state = S_SETUP;
                    w_next_cnt   = SETUP_LD;
                end else begin
                    w_next_state = S_WAIT_TX;
                    w_next_cnt   = 4'd0;
                end
            end
`endif
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_STROBE;
                    w_next_cnt   = PULSE_LD;
                end else begin
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_HOLD;
                    w_next_cnt   = HOLD_LD;
                end else begin
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_DONE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // The operation is latched only when an access is accepted from IDLE.
    always_comb begin
        w_next_write = r_is_write;
        if ((r_state == S_IDLE) && w_req) begin
            w_next_write = w_req_write;
        end else begin
            w_next_write = r_is_write;
        end
    end

    // State, counter, strobes and data registers; strobes are decoded from the next state so they align with it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_rdn      <= 1'b1;
            r_wrn      <= 1'b1;
            r_bus_oe   <= 1'b0;
            r_bus_dout <= 16'd0;
            r_rdata    <= 16'd0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_is_write <= w_next_write;
            r_rdn      <= ~(~w_next_write && (w_next_state == S_STROBE));
            r_wrn      <= ~(w_next_write && (w_next_state == S_STROBE));
            r_bus_oe   <= w_next_write && ((w_next_state == S_SETUP) ||
                                           (w_next_state == S_STROBE) ||
                                           (w_next_state == S_HOLD));
            if ((r_state == S_IDLE) && w_req) begin
                r_bus_dout <= WData;
            end
            if ((r_state == S_STROBE) && (r_cnt == 4'd0) && !r_is_write) begin
                r_rdata <= bus_din;
            end
        end
    end

    assign w_busy = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD) ||
                    (r_state == S_WAIT_TX);

    // DONE is deliberately absent so the pipeline advances on the edge that leaves it.
    always_comb begin
        Stall = 1'b0;
        if (Rst) begin
            Stall = 1'b0;
        end else begin
            Stall = ((r_state == S_IDLE) && w_req) || w_busy;
        end
    end

    // Status reads bypass the FSM; everything else returns the last captured read.
    always_comb begin
        RData = r_rdata;
        if (w_status_rd) begin
            RData = status_word(data_ready, w_tx_ready);
        end else begin
            RData = r_rdata;
        end
    end

    assign rdn      = r_rdn;
    assign wrn      = r_wrn;
    assign bus_oe   = r_bus_oe;
    assign bus_dout = r_bus_dout;

endmodule
